// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin shared serial pattern counter, one result per granted word
module pattern_scan_arbiter #(
    parameter int                 NREQ    = 4,
    parameter int                 WORD_W  = 16,
    parameter int                 PAT_LEN = 7,
    parameter logic [PAT_LEN-1:0] PATTERN = 7'b1010101,
    parameter int                 CNT_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WORD_W-1:0]    data,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [CNT_W-1:0]          hit_count,
    output logic                      found
);
    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d, cur_id_q, cur_id_d, done_id_q, done_id_d, pick;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [PAT_LEN-1:0]  win_q, win_d, win_n;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    acc_q, acc_d, hit_count_q, hit_count_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                busy_q, busy_d, done_q, done_d, found_q, found_d, hit;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v >= NREQ ? v - NREQ : v);
    endfunction

    assign win_n = PAT_LEN'({win_q, sr_q[WORD_W-1]});
    assign hit   = (win_n == PATTERN) && (int'(bit_cnt_q) >= PAT_LEN - 1);

    // first requester at or after rr_ptr, wrapping; lowest offset wins
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[wrap(int'(rr_ptr_q) + i)]) pick = wrap(int'(rr_ptr_q) + i);
    end

    // next-state and datapath: capture in IDLE, one bit per SHIFT edge, commit on the extra edge after the last bit
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        done_id_d   = done_id_q;
        sr_d        = sr_q;
        win_d       = win_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        hit_count_d = hit_count_q;
        found_d     = found_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                sr_d      = data[pick*WORD_W +: WORD_W];
                win_d     = '0;
                bit_cnt_d = '0;
                acc_d     = '0;
                gnt_d     = NREQ'(1) << pick;
                rr_ptr_d  = wrap(int'(pick) + 1);
                cur_id_d  = pick;
                state_d   = LOAD;
            end
            LOAD: state_d = SHIFT;
            SHIFT: if (bit_cnt_q != BCW'(WORD_W)) begin
                sr_d      = sr_q << 1;
                win_d     = win_n;
                bit_cnt_d = bit_cnt_q + 1'b1;
                acc_d     = acc_q + CNT_W'(hit);
            end else begin
                hit_count_d = acc_q;
                found_d     = |acc_q;
                done_id_d   = cur_id_q;
                done_d      = 1'b1;
                state_d     = REPORT;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            done_id_q   <= '0;
            sr_q        <= '0;
            win_q       <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            hit_count_q <= '0;
            found_q     <= 1'b0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            done_id_q   <= done_id_d;
            sr_q        <= sr_d;
            win_q       <= win_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            hit_count_q <= hit_count_d;
            found_q     <= found_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign hit_count = hit_count_q;
    assign found     = found_q;
endmodule
